sata_oob_controller: RTL and testbench

- Host-side SATA OOB link-initialization sequencer.
- Drives the OOB encoder through COMRESET and COMWAKE bursts, and consumes the cominit/comwake/oobfinish pulses from the OOB decoder.
- Applies per-phase timeouts and bounded COMRESET retries, then reports link-up or failure to the link layer.

---
 rtl/sata_oob_if.sv | 29 ++
 rtl/sata_oob_controller.sv | 135 +++++++++++++
 tb/tb_sata_oob_controller.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sata_oob_if.sv
// Signal bundle between the OOB sequencer, the OOB encoder/decoder and the link layer.
// master = sequencer side, slave = encoder/decoder/link-layer side.
interface sata_oob_if #(
    parameter int unsigned RETRY_MAX = 8
);
    localparam int unsigned RetryW = $clog2(RETRY_MAX + 1);

    logic              start;
    logic              cominit;
    logic              comwake;
    logic              oobfinish;
    logic              tx_busy;
    logic              tx_comreset;
    logic              tx_comwake;
    logic              linkup;
    logic              fail;
    logic [RetryW-1:0] retry_cnt;
    logic [3:0]        state;

    modport master (
        input  start, cominit, comwake, oobfinish, tx_busy,
        output tx_comreset, tx_comwake, linkup, fail, retry_cnt, state
    );

    modport slave (
        output start, cominit, comwake, oobfinish, tx_busy,
        input  tx_comreset, tx_comwake, linkup, fail, retry_cnt, state
    );
endinterface

// File: rtl/sata_oob_controller.sv
// Host-side SATA OOB link-initialization sequencer: COMRESET/COMWAKE encoder handshakes,
// per-phase response timeouts and bounded COMRESET retries.
module sata_oob_controller #(
    parameter int unsigned TIMEOUT   = 32768,
    parameter int unsigned RETRY_MAX = 8
) (
    input logic        clk,
    input logic        reset,
    sata_oob_if.master bus
);
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    localparam int unsigned RetryW = $clog2(RETRY_MAX + 1);

    typedef enum logic [3:0] {
        StIdle             = 4'd0,
        StSendComreset     = 4'd1,
        StWaitComresetDone = 4'd2,
        StWaitCominit      = 4'd3,
        StSendComwake      = 4'd4,
        StWaitComwakeDone  = 4'd5,
        StWaitComwakeRx    = 4'd6,
        StWaitOobfinish    = 4'd7,
        StLinkup           = 4'd8,
        StFail             = 4'd9
    } state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic                pending_q, pending_d;
    logic                tx_comreset_q, tx_comwake_q, linkup_q, fail_q;

    logic waiting;
    logic timed_out;
    logic entering;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        pending_d = pending_q;
        waiting   = (state_q == StWaitCominit) || (state_q == StWaitComwakeRx) ||
                    (state_q == StWaitOobfinish);
        timed_out = waiting && (timer_q == TimerW'(TIMEOUT));

        if (bus.start) begin
            state_d   = StSendComreset;
            retry_d   = '0;
            pending_d = 1'b0;
        end else begin
            // The device may answer COMINIT while our own COMRESET burst is still on the line.
            if (bus.cominit && ((state_q == StSendComreset) || (state_q == StWaitComresetDone))) begin
                pending_d = 1'b1;
            end

            unique case (state_q)
                StIdle: ;
                StSendComreset:     if (bus.tx_busy)  state_d = StWaitComresetDone;
                StWaitComresetDone: if (!bus.tx_busy) state_d = StWaitCominit;
                StWaitCominit: begin
                    if (bus.cominit || pending_q) begin
                        state_d   = StSendComwake;
                        pending_d = 1'b0;
                    end
                end
                StSendComwake:      if (bus.tx_busy)  state_d = StSendComwake == state_q ?
                                                                StWaitComwakeDone : state_q;
                StWaitComwakeDone:  if (!bus.tx_busy) state_d = StWaitComwakeRx;
                StWaitComwakeRx: begin
                    if (bus.cominit)      state_d = StSendComwake;
                    else if (bus.comwake) state_d = StWaitOobfinish;
                end
                StWaitOobfinish: begin
                    if (bus.cominit)        state_d = StSendComwake;
                    else if (bus.oobfinish) state_d = StLinkup;
                end
                StLinkup:           if (bus.cominit)  state_d = StSendComwake;
                StFail: ;
                default:            state_d = StIdle;
            endcase

            // Any qualifying event in the timeout cycle has already moved state_d.
            if (timed_out && (state_d == state_q)) begin
                if (retry_q < RetryW'(RETRY_MAX)) begin
                    retry_d = retry_q + RetryW'(1);
                    state_d = StSendComreset;
                end else begin
                    state_d = StFail;
                end
            end
        end

        entering = bus.start || (state_d != state_q);
        if (entering && (state_d == StSendComreset)) begin
            pending_d = 1'b0;
        end

        if (entering) begin
            timer_d = '0;
        end else if (waiting && (timer_q != TimerW'(TIMEOUT))) begin
            timer_d = timer_q + TimerW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            retry_q       <= '0;
            pending_q     <= 1'b0;
            tx_comreset_q <= 1'b0;
            tx_comwake_q  <= 1'b0;
            linkup_q      <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            pending_q     <= pending_d;
            // Outputs are registered from the next state so they track state_q exactly.
            tx_comreset_q <= (state_d == StSendComreset);
            tx_comwake_q  <= (state_d == StSendComwake);
            linkup_q      <= (state_d == StLinkup);
            fail_q        <= (state_d == StFail);
        end
    end

    assign bus.tx_comreset = tx_comreset_q;
    assign bus.tx_comwake  = tx_comwake_q;
    assign bus.linkup      = linkup_q;
    assign bus.fail        = fail_q;
    assign bus.retry_cnt   = retry_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_sata_oob_controller.sv
// Self-checking bench for sata_oob_controller: vector table, directed corner cases and a
// randomized run against a rule-based reference model.
module tb_sata_oob_controller;
    localparam int unsigned TO = 64;
    localparam int unsigned RM = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    sata_oob_if #(.RETRY_MAX(RM)) bus ();

    sata_oob_controller #(.TIMEOUT(TO), .RETRY_MAX(RM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s, ci, cw, of, b;
        logic [9:0] exp;
    } vec_t;

    // Reference model state (spec state codes as plain integers).
    int m_st, m_tmr, m_ret;
    bit m_pend;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // {state, tx_comreset, tx_comwake, linkup, fail, retry_cnt}
    function automatic logic [9:0] outs();
        return {bus.state, bus.tx_comreset, bus.tx_comwake, bus.linkup, bus.fail, bus.retry_cnt};
    endfunction

    function automatic logic [9:0] pack(input int st, input int ret);
        logic [3:0] s4;
        logic [1:0] r2;
        s4 = 4'(st);
        r2 = 2'(ret);
        return {s4, st == 1, st == 4, st == 8, st == 9, r2};
    endfunction

    function automatic vec_t mk(input logic s, ci, cw, of, b, input int st);
        vec_t v;
        v.s = s; v.ci = ci; v.cw = cw; v.of = of; v.b = b;
        v.exp = pack(st, 0);
        return v;
    endfunction

    task automatic cyc(input logic s, ci, cw, of, b);
        bus.start = s; bus.cominit = ci; bus.comwake = cw; bus.oobfinish = of; bus.tx_busy = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        bus.start = 0; bus.cominit = 0; bus.comwake = 0; bus.oobfinish = 0; bus.tx_busy = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_ret = 0; m_pend = 0;
    endtask

    // Rules applied in priority order: restart, device reset, phase progress, timeout.
    task automatic model_step(input bit s, ci, cw, of, b);
        int nxt;
        bit wait_ph;
        nxt     = m_st;
        wait_ph = (m_st == 3 || m_st == 6 || m_st == 7);
        if (s) begin
            nxt   = 1;
            m_ret = 0;
        end else if (ci && m_st >= 6 && m_st <= 8) begin
            nxt = 4;
        end else begin
            case (m_st)
                1: if (b) nxt = 2;
                2: if (!b) nxt = 3;
                3: if (ci || m_pend) nxt = 4;
                4: if (b) nxt = 5;
                5: if (!b) nxt = 6;
                6: if (cw) nxt = 7;
                7: if (of) nxt = 8;
                default: ;
            endcase
            if (wait_ph && nxt == m_st && m_tmr == TO) begin
                if (m_ret < RM) begin
                    m_ret++;
                    nxt = 1;
                end else begin
                    nxt = 9;
                end
            end
        end
        if (!s && ci && (m_st == 1 || m_st == 2)) m_pend = 1;
        if (m_st == 3 && nxt == 4) m_pend = 0;
        if (nxt == 1 && (s || m_st != 1)) m_pend = 0;
        if (s || nxt != m_st) m_tmr = 0;
        else if (wait_ph && m_tmr < TO) m_tmr++;
        m_st = nxt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[20];
        int   cnt;
        int   hs;
        logic s, ci, cw, of, b;
        bit   quiet;

        // ---------------- vector table ----------------
        tbl[0]  = mk(1, 0, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 1, 2);
        tbl[3]  = mk(0, 1, 0, 0, 1, 2);   // early COMINIT during burst
        tbl[4]  = mk(0, 0, 0, 0, 0, 3);
        tbl[5]  = mk(0, 0, 0, 0, 0, 4);   // pending flag: WAIT_COMINIT lasts one cycle
        tbl[6]  = mk(0, 0, 1, 0, 0, 4);   // stray comwake ignored
        tbl[7]  = mk(0, 1, 0, 0, 1, 5);   // cominit ignored in SEND_COMWAKE
        tbl[8]  = mk(0, 0, 0, 0, 1, 5);
        tbl[9]  = mk(0, 0, 0, 0, 0, 6);
        tbl[10] = mk(0, 0, 1, 0, 0, 7);
        tbl[11] = mk(0, 0, 0, 0, 0, 7);
        tbl[12] = mk(0, 0, 0, 1, 0, 8);
        tbl[13] = mk(0, 0, 1, 1, 0, 8);
        tbl[14] = mk(0, 1, 0, 0, 0, 4);   // device reset from LINKUP
        tbl[15] = mk(0, 0, 0, 0, 1, 5);
        tbl[16] = mk(0, 0, 0, 0, 0, 6);
        tbl[17] = mk(0, 0, 1, 0, 0, 7);
        tbl[18] = mk(0, 0, 0, 1, 0, 8);
        tbl[19] = mk(1, 1, 0, 0, 0, 1);   // start beats cominit

        do_reset();
        check("reset_outs", 32'(outs()), 32'(pack(0, 0)));
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].s, tbl[i].ci, tbl[i].cw, tbl[i].of, tbl[i].b);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // ---------------- nominal timing ----------------
        do_reset();
        cyc(1, 0, 0, 0, 0);
        check("nom_send_comreset", 32'(outs()), 32'(pack(1, 0)));
        cyc(0, 0, 0, 0, 1);
        check("nom_st2", bus.state, 2);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("nom_st3", bus.state, 3);
        idle(9);
        cyc(0, 1, 0, 0, 0);
        check("nom_send_comwake", 32'(outs()), 32'(pack(4, 0)));
        cyc(0, 0, 0, 0, 1);
        check("nom_st5", bus.state, 5);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("nom_st6", bus.state, 6);
        idle(9);
        cyc(0, 0, 1, 0, 0);
        check("nom_st7", bus.state, 7);
        idle(4);
        cyc(0, 0, 0, 1, 0);
        check("nom_linkup", 32'(outs()), 32'(pack(8, 0)));

        // ---------------- no device: retries then FAIL ----------------
        do_reset();
        cyc(1, 0, 0, 0, 0);
        hs = 0;
        for (int a = 0; a < 3; a++) begin
            cnt = 0;
            while (!bus.tx_comreset && cnt < 10) begin
                cyc(0, 0, 0, 0, 0);
                cnt++;
            end
            check($sformatf("nodev_req%0d", a), bus.tx_comreset, 1);
            if (bus.tx_comreset) hs++;
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0);
            cnt = 0;
            while (bus.state == 4'd3 && cnt < 200) begin
                cnt++;
                cyc(0, 0, 0, 0, 0);
            end
            check($sformatf("nodev_wait%0d", a), cnt, TO + 1);
            if (a < 2) check($sformatf("nodev_retry%0d", a), 32'(outs()), 32'(pack(1, a + 1)));
        end
        check("nodev_handshakes", hs, 3);
        check("nodev_fail", 32'(outs()), 32'(pack(9, 2)));
        idle(3);
        check("fail_sticky", 32'(outs()), 32'(pack(9, 2)));
        cyc(1, 0, 0, 0, 0);
        check("restart_from_fail", 32'(outs()), 32'(pack(1, 0)));

        // ---------------- comwake in the timeout cycle ----------------
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("sim_st6", bus.state, 6);
        idle(TO);
        check("sim_before_to", 32'(outs()), 32'(pack(6, 0)));
        cyc(0, 0, 1, 0, 0);
        check("sim_comwake_wins", 32'(outs()), 32'(pack(7, 0)));

        // ---------------- start together with cominit in WAIT_COMINIT ----------------
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("start_beats_cominit", 32'(outs()), 32'(pack(1, 0)));

        // ---------------- async reset in WAIT_OOBFINISH with retry_cnt=1 ----------------
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        idle(TO + 1);
        check("rst_retry1", 32'(outs()), 32'(pack(1, 1)));
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("rst_st7", 32'(outs()), 32'(pack(7, 1)));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(outs()), 32'(pack(0, 0)));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- randomized run against reference model ----------------
        do_reset();
        model_reset();
        for (int i = 0; i < 6000; i++) begin
            quiet = ((i / 300) % 2) == 1;
            s  = !quiet && ($urandom_range(0, 99) < 2);
            ci = !quiet && ($urandom_range(0, 99) < 8);
            cw = !quiet && ($urandom_range(0, 99) < 10);
            of = !quiet && ($urandom_range(0, 99) < 25);
            b  = ($urandom_range(0, 99) < 40);
            cyc(s, ci, cw, of, b);
            model_step(s, ci, cw, of, b);
            check($sformatf("rand%0d", i), 32'(outs()), 32'(pack(m_st, m_ret)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
